// File: rtl/wrapper_pkg.sv
// Shared definitions for the SPI memory subsystem: sizes, slave FSM states, command codes.
package wrapper_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;
  localparam int WORD_W    = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_ram.sv
// Single-port 256 x 8 synchronous RAM driven by 10-bit command words from the SPI slave.
module spi_ram #(
  parameter int MEM_DEPTH = wrapper_pkg::MEM_DEPTH,
  parameter int ADDR_SIZE = wrapper_pkg::ADDR_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);
  import wrapper_pkg::*;

  logic [7:0]           mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  cmd_t                 cmd;

  assign cmd = cmd_t'(din[9:8]);

  // Array kept outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rx_valid && (cmd == WR_DATA))
      mem[wr_addr] <= din[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
          RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
          RD_DATA: begin
            dout     <= mem[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: frame FSM, 10-bit word deserialiser and 8-bit MISO serialiser.
//   state     | meaning
//   IDLE      | waiting for SS_n low
//   CHK_CMD   | sampling selector bit (0 = write path, 1 = read path)
//   WRITE     | shifting in a write-address / write-data word
//   READ_ADD  | shifting in a read-address word
//   READ_DATA | shifting in read-data command, then shifting RAM byte out on MISO
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);
  import wrapper_pkg::*;

  state_t     state;
  state_t     next_state;
  logic [3:0] rx_cnt;
  logic [3:0] tx_cnt;
  logic [7:0] tx_shift;
  logic       rd_addr_seen;

  logic       load_rx;
  logic       shift_en;
  logic       word_done;
  logic       tx_load;
  logic       tx_shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_seen) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_rx     = (state == CHK_CMD) && !SS_n;
    shift_en    = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA))
                  && !SS_n && (rx_cnt != 4'd0);
    word_done   = shift_en && (rx_cnt == 4'd1);
    tx_load     = (state == READ_DATA) && !SS_n && tx_valid;
    tx_shift_en = (state == READ_DATA) && !SS_n && (tx_cnt != 4'd0);
  end

  // rx_cnt and tx_cnt are down-counters; zero means "nothing left to move".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= 4'd0;
      tx_cnt   <= 4'd0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_shift <= '0;
      MISO     <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (SS_n) begin
        rx_cnt <= 4'd0;
        tx_cnt <= 4'd0;
        MISO   <= 1'b0;
      end else begin
        if (load_rx)
          rx_cnt <= 4'd10;
        else if (shift_en) begin
          rx_data <= {rx_data[8:0], MOSI};
          rx_cnt  <= rx_cnt - 4'd1;
        end
        if (tx_load) begin
          MISO     <= tx_data[7];
          tx_shift <= {tx_data[6:0], 1'b0};
          tx_cnt   <= 4'd7;
        end else if (tx_shift_en) begin
          MISO     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
          tx_cnt   <= tx_cnt - 4'd1;
        end else begin
          MISO <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_addr_seen <= 1'b0;
    else if (word_done && (state == READ_ADD))
      rd_addr_seen <= 1'b1;
    else if (tx_shift_en && (tx_cnt == 4'd1))
      rd_addr_seen <= 1'b0;
  end

endmodule

// File: rtl/wrapper.sv
// SPI memory subsystem top: SPI slave front end feeding a 256 x 8 RAM.
module wrapper #(
  parameter int MEM_DEPTH = wrapper_pkg::MEM_DEPTH,
  parameter int ADDR_SIZE = wrapper_pkg::ADDR_SIZE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  spi_slave SPI_SLAVE_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  spi_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) SPI_RAM_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (rx_data),
    .rx_valid (rx_valid),
    .dout     (tx_data),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_wrapper.sv
// Directed bench for the SPI memory subsystem: frame vector table plus abort and reset corner cases.
module tb_wrapper;
  import wrapper_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int tests = 0;
  int fails = 0;

  wrapper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sel;
    logic [9:0] word;
    int         kind;      // 0 wr_addr, 1 mem[addr], 2 rd_addr, 3 read-out only
    logic [7:0] addr;
    logic [7:0] exp;
    logic [7:0] exp_miso;
    logic       exp_seen;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic sel, input logic [9:0] word,
                           output logic [7:0] miso_byte, output logic trail);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = sel;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk); MOSI = word[i];
    end
    @(negedge clk); MOSI = 1'b0;
    @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); miso_byte[i] = MISO;
    end
    @(negedge clk); trail = MISO;
    SS_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [7:0] mb;
  logic       tr;

  initial begin
    vecs[0]  = '{1'b0, 10'b00_1111_1111, 0, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 10'b01_1111_1111, 1, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 10'b10_1111_1111, 2, 8'h00, 8'hFF, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 10'b11_0000_0000, 3, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[4]  = '{1'b0, 10'b00_0011_1100, 0, 8'h00, 8'h3C, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 10'b01_1010_0101, 1, 8'h3C, 8'hA5, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 10'b10_0011_1100, 2, 8'h00, 8'h3C, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 10'b11_0000_0000, 3, 8'h00, 8'h00, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 10'b00_0000_0000, 0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 10'b01_0101_1010, 1, 8'h00, 8'h5A, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 10'b10_0000_0000, 2, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 10'b11_0000_0000, 3, 8'h00, 8'h00, 8'h5A, 1'b0};
    vecs[12] = '{1'b1, 10'b10_1111_1111, 2, 8'h00, 8'hFF, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 10'b11_0011_1100, 3, 8'h00, 8'h00, 8'hFF, 1'b0};

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_state", 32'(dut.SPI_SLAVE_inst.state), 32'(IDLE));
    check("reset_seen", 32'(dut.SPI_SLAVE_inst.rd_addr_seen), 32'd0);
    check("reset_wr_addr", 32'(dut.SPI_RAM_inst.wr_addr), 32'd0);
    check("reset_rd_addr", 32'(dut.SPI_RAM_inst.rd_addr), 32'd0);
    check("reset_tx_valid", 32'(dut.SPI_RAM_inst.tx_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_miso", 32'(MISO), 32'd0);

    for (int v = 0; v < 14; v++) begin
      run_frame(vecs[v].sel, vecs[v].word, mb, tr);
      check($sformatf("v%0d_miso_byte", v), 32'(mb), 32'(vecs[v].exp_miso));
      check($sformatf("v%0d_miso_trail", v), 32'(tr), 32'd0);
      check($sformatf("v%0d_seen", v), 32'(dut.SPI_SLAVE_inst.rd_addr_seen), 32'(vecs[v].exp_seen));
      check($sformatf("v%0d_state", v), 32'(dut.SPI_SLAVE_inst.state), 32'(IDLE));
      case (vecs[v].kind)
        0: check($sformatf("v%0d_wr_addr", v), 32'(dut.SPI_RAM_inst.wr_addr), 32'(vecs[v].exp));
        1: check($sformatf("v%0d_mem", v), 32'(dut.SPI_RAM_inst.mem[vecs[v].addr]), 32'(vecs[v].exp));
        2: check($sformatf("v%0d_rd_addr", v), 32'(dut.SPI_RAM_inst.rd_addr), 32'(vecs[v].exp));
        default: ;
      endcase
    end

    // Aborted write-data frame after 5 word bits must leave memory alone.
    run_frame(1'b0, 10'b00_0011_1100, mb, tr);
    check("abort_setup_wr_addr", 32'(dut.SPI_RAM_inst.wr_addr), 32'h3C);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = 1'b0;
    for (int i = 9; i >= 5; i--) begin
      @(negedge clk); MOSI = (10'b01_0101_1010 >> i) & 10'd1;
    end
    @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(dut.SPI_SLAVE_inst.state), 32'(IDLE));
    check("abort_miso", 32'(MISO), 32'd0);
    check("abort_rx_valid", 32'(dut.SPI_SLAVE_inst.rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_mem_kept", 32'(dut.SPI_RAM_inst.mem[8'h3C]), 32'hA5);
    run_frame(1'b0, 10'b01_0111_0111, mb, tr);
    check("after_abort_mem", 32'(dut.SPI_RAM_inst.mem[8'h3C]), 32'h77);
    check("after_abort_mem0", 32'(dut.SPI_RAM_inst.mem[8'h00]), 32'h5A);

    // Reset asserted while READ_DATA is shifting out 8'h77.
    run_frame(1'b1, 10'b10_0011_1100, mb, tr);
    check("rst_seq_seen", 32'(dut.SPI_SLAVE_inst.rd_addr_seen), 32'd1);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk); MOSI = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk); MOSI = (i >= 8) ? 1'b1 : 1'b0;
    end
    @(negedge clk); MOSI = 1'b0;
    @(negedge clk);
    @(negedge clk); check("rst_seq_bit7", 32'(MISO), 32'd0);
    @(negedge clk); check("rst_seq_bit6", 32'(MISO), 32'd1);
    @(negedge clk); check("rst_seq_bit5", 32'(MISO), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_miso", 32'(MISO), 32'd0);
    check("rst_mid_state", 32'(dut.SPI_SLAVE_inst.state), 32'(IDLE));
    check("rst_mid_seen", 32'(dut.SPI_SLAVE_inst.rd_addr_seen), 32'd0);
    check("rst_mid_mem3c", 32'(dut.SPI_RAM_inst.mem[8'h3C]), 32'h77);
    check("rst_mid_memff", 32'(dut.SPI_RAM_inst.mem[8'hFF]), 32'hFF);
    SS_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rd_addr", 32'(dut.SPI_RAM_inst.rd_addr), 32'd0);
    run_frame(1'b1, 10'b10_0000_0000, mb, tr);
    check("post_rst_seen", 32'(dut.SPI_SLAVE_inst.rd_addr_seen), 32'd1);
    run_frame(1'b1, 10'b11_0000_0000, mb, tr);
    check("post_rst_read", 32'(mb), 32'h5A);
    check("post_rst_trail", 32'(tr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
